// File: rtl/pulse_period_meter.sv
// Slices an 8-bit pulse stream with hysteresis and measures clocks between level toggles.
// Optional feature macro: PERIOD_FILTER_EN (accept a measurement only when it repeats).
module pulse_period_meter #(
    parameter logic [7:0] THRESH_HI = 8'hC0,
    parameter logic [7:0] THRESH_LO = 8'h40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sample,
    output logic [11:0] period,
    output logic        valid,
    output logic        locked,
    output logic        timeout,
    output logic        level
);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t      state;
    state_t      state_next;
    logic [11:0] cnt;
    logic        level_next;
    logic        edge_hit;
    logic        cnt_full;
    logic        take;
    logic        accept;
    logic        reject;
    logic        expire;

`ifdef PERIOD_FILTER_EN
    logic [11:0] prev;
    logic        have_prev;
`endif

    always_comb begin
        level_next = level;
        if (sample >= THRESH_HI) begin
            level_next = 1'b1;
        end else if (sample <= THRESH_LO) begin
            level_next = 1'b0;
        end
    end

    assign edge_hit = (level_next != level);
    assign cnt_full = (cnt == 12'hFFF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (edge_hit) state_next = MEAS;
            MEAS:    if (!edge_hit && cnt_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An edge always beats saturation, so m = 4095 is a real measurement.
    always_comb begin
        take   = (state == MEAS) && edge_hit;
        expire = (state == MEAS) && !edge_hit && cnt_full;
`ifdef PERIOD_FILTER_EN
        accept = take && have_prev && (cnt == prev);
        reject = take && !(have_prev && (cnt == prev));
`else
        accept = take;
        reject = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level   <= 1'b0;
            cnt     <= 12'd0;
            period  <= 12'd0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            level   <= level_next;
            valid   <= accept;
            timeout <= expire;
            if (accept) begin
                period <= cnt;
            end
            if (accept) begin
                locked <= 1'b1;
            end else if (reject || expire) begin
                locked <= 1'b0;
            end
            if (state == IDLE || edge_hit || expire) begin
                cnt <= 12'd0;
            end else if (!cnt_full) begin
                cnt <= cnt + 12'd1;
            end
        end
    end

`ifdef PERIOD_FILTER_EN
    // The first measurement after IDLE has nothing to compare against; it only seeds prev.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev      <= 12'd0;
            have_prev <= 1'b0;
        end else if (expire) begin
            prev      <= 12'd0;
            have_prev <= 1'b0;
        end else if (take) begin
            prev      <= cnt;
            have_prev <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: timestamp-based reference model plus literal pins.
module tb_pulse_period_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sample = 8'h00;
    logic [11:0] period;
    logic        valid;
    logic        locked;
    logic        timeout;
    logic        level;

    pulse_period_meter dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .period(period),
        .valid(valid), .locked(locked), .timeout(timeout), .level(level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state, expressed as timestamps of level toggles
    logic m_level = 1'b0;
    bit   m_meas = 1'b0;
    int   m_last_edge = 0;
    int   m_prev = 0;
    bit   m_have_prev = 1'b0;
    int   e_period = 0;
    bit   e_valid = 1'b0;
    bit   e_locked = 1'b0;
    bit   e_timeout = 1'b0;

    // observations gathered by the compare process
    bit   chk_on = 1'b0;
    int   v_cnt = 0;
    int   to_cnt = 0;
    int   falls = 0;
    int   last_chg = 0;
    int   to_tick = 0;
    logic lvl_seen = 1'b0;
    logic gen_lvl = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_step();
        logic nl;
        int   m;
        cyc++;
        e_valid   = 1'b0;
        e_timeout = 1'b0;
        if (!rst_n) begin
            m_level = 1'b0; m_meas = 1'b0; m_prev = 0; m_have_prev = 1'b0;
            e_period = 0; e_locked = 1'b0;
            return;
        end
        nl = (sample >= 8'hC0) ? 1'b1 : (sample <= 8'h40) ? 1'b0 : m_level;
        if (!m_meas) begin
            if (nl != m_level) begin
                m_meas = 1'b1;
                m_last_edge = cyc;
            end
        end else if (nl != m_level) begin
            m = cyc - m_last_edge - 1;
            if (m > 4095) m = 4095;
            m_last_edge = cyc;
`ifdef PERIOD_FILTER_EN
            if (m_have_prev && m == m_prev) begin
                e_period = m; e_valid = 1'b1; e_locked = 1'b1;
            end else begin
                e_locked = 1'b0;
            end
            m_prev = m;
            m_have_prev = 1'b1;
`else
            e_period = m; e_valid = 1'b1; e_locked = 1'b1;
`endif
        end else if (cyc - m_last_edge == 4096) begin
            e_timeout = 1'b1; e_locked = 1'b0; m_meas = 1'b0;
            m_prev = 0; m_have_prev = 1'b0;
        end
        m_level = nl;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("period", period, e_period);
            check("valid", valid, e_valid);
            check("locked", locked, e_locked);
            check("timeout", timeout, e_timeout);
            check("level", level, m_level);
            check("valid_timeout_excl", valid & timeout, 0);
            if (valid) v_cnt++;
            if (timeout) begin
                to_cnt++;
                to_tick = cyc;
            end
            if (level !== lvl_seen) begin
                if (!level) falls++;
                last_chg = cyc;
                lvl_seen = level;
            end
        end
    end

    task automatic tick(input logic [7:0] s);
        sample = s;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    // generator model: each half toggles the level and holds it for cm+1 clocks
    task automatic gen(input int cm, input int halves);
        for (int h = 0; h < halves; h++) begin
            gen_lvl = ~gen_lvl;
            for (int k = 0; k <= cm; k++) tick(gen_lvl ? 8'hFF : 8'h00);
        end
    endtask

    int v0;
    int t0;
    int f0;

    initial begin
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        tick(8'h00);
        chk_on = 1'b1;
        tick(8'h00);
        check("rst_period", period, 0);
        check("rst_locked", locked, 0);
        check("rst_level", level, 0);
        rst_n = 1'b1;

        // steady count_max = 9
        v0 = v_cnt;
        gen(9, 6);
`ifdef PERIOD_FILTER_EN
        check("cm9_valids", v_cnt - v0, 4);
`else
        check("cm9_valids", v_cnt - v0, 5);
`endif
        check("cm9_period", period, 9);
        check("cm9_locked", locked, 1);

        // frequency step to count_max = 20
        gen(20, 2);
`ifdef PERIOD_FILTER_EN
        check("step_period_hold", period, 9);
        check("step_locked_drop", locked, 0);
`else
        check("step_period_new", period, 20);
        check("step_locked", locked, 1);
`endif
        gen(20, 1);
        check("step_period", period, 20);
        check("step_relock", locked, 1);

        // hysteresis band never toggles the level
        f0 = falls;
        tick(8'hFF); tick(8'h80); tick(8'h50); tick(8'h80); tick(8'hFF);
        check("hyst_level_high", level, 1);
        tick(8'h30);
        check("hyst_level_low", level, 0);
        check("hyst_falls", falls - f0, 1);
        gen_lvl = 1'b0;

        // lock on count_max = 5, then starve the input
        gen(5, 5);
        check("cm5_period", period, 5);
        check("cm5_locked", locked, 1);
        t0 = to_cnt;
        for (int i = 0; i < 4100; i++) tick(8'hFF);
        check("to_count", to_cnt - t0, 1);
        check("to_delay", to_tick - last_chg, 4096);
        check("to_locked", locked, 0);
        check("to_period", period, 5);
        v0 = v_cnt;
        gen(5, 2);
`ifdef PERIOD_FILTER_EN
        check("reentry_valids", v_cnt - v0, 0);
`else
        check("reentry_valids", v_cnt - v0, 1);
`endif

        // boundary: 4096-clock halves measure 4095 with no timeout
        t0 = to_cnt;
        gen(4095, 3);
        check("max_period", period, 4095);
        check("max_no_timeout", to_cnt - t0, 0);
        check("max_locked", locked, 1);

        // boundary: toggle every clock
        gen(0, 6);
        check("min_period", period, 0);
        check("min_locked", locked, 1);

        // reset mid-measurement while locked
        gen(9, 4);
        check("pre_rst_locked", locked, 1);
        for (int k = 0; k < 4; k++) tick(gen_lvl ? 8'hFF : 8'h00);
        rst_n = 1'b0;
        tick(gen_lvl ? 8'hFF : 8'h00);
        check("mid_rst_period", period, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_level", level, 0);
        rst_n = 1'b1;
        gen_lvl = 1'b0;
        v0 = v_cnt;
        gen(9, 4);
`ifdef PERIOD_FILTER_EN
        check("post_rst_valids", v_cnt - v0, 2);
`else
        check("post_rst_valids", v_cnt - v0, 3);
`endif
        check("post_rst_period", period, 9);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
